// File: rtl/sntrup_pkg.sv
// rtl/sntrup_pkg.sv - shared SNTRUP757 constants and types
package sntrup_pkg;

    localparam int P      = 757;
    localparam int COEF_W = 26;
    localparam int ADDR_W = 11;
    localparam int DEG_W  = 11;

    typedef logic [COEF_W-1:0] coef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/dist_ram_sp.sv
// rtl/dist_ram_sp.sv - distributed RAM, one synchronous write port, one asynchronous read port
module dist_ram_sp #(
    parameter int DATA_W = 26,
    parameter int DEPTH  = 757,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Callers range-check raddr; indices past DEPTH are masked upstream.
    assign rdata = mem[raddr];

endmodule

// File: rtl/coef_ram_ctrl.sv
// rtl/coef_ram_ctrl.sv - range-checked coefficient store with degree register and clear sequencer
module coef_ram_ctrl
    import sntrup_pkg::*;
#(
    parameter int DATA_W = COEF_W,
    parameter int ADDR_W = sntrup_pkg::ADDR_W,
    parameter int DEPTH  = P,
    parameter int RD_REG = 1,
    parameter int DEG_W  = sntrup_pkg::DEG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              deg_we,
    input  logic [DEG_W-1:0]  deg_in,
    output logic [DEG_W-1:0]  deg_out
);

    // Narrowest index that reaches every stored coefficient.
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        state;
    clr_state_t        state_n;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              clr_go;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_mux;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign clr_last    = (clr_cnt == LAST_ADDR);
    assign clr_go      = (state == IDLE) && clr_start;
    assign busy        = (state == CLEAR);

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: clear runs until the last coefficient has been written.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (clr_start) state_n = CLEAR;
            CLEAR:   if (clr_last)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Clear address counter; parked at zero whenever the sequencer is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (clr_go) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);
        end
    end

    // Write-port mux: the sequencer owns the port while clearing.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr[IDX_W-1:0];
        ram_wdata = wr_data;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt[IDX_W-1:0];
            ram_wdata = '0;
        end else if (wr_en && wr_in_range) begin
            ram_we    = 1'b1;
        end
    end

    // One-cycle error flag for writes that were dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && (busy || !wr_in_range);
        end
    end

    // Degree register; a clear request takes priority over a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deg_out <= '0;
        end else if (clr_go) begin
            deg_out <= '0;
        end else if ((state == IDLE) && deg_we) begin
            deg_out <= deg_in;
        end
    end

    dist_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    assign rd_mux = rd_in_range ? ram_rdata : '0;

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            // Registered read samples pre-edge contents, giving read-first ordering.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_en;
                    if (rd_en) begin
                        rd_data_q <= rd_mux;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_rd_comb
            assign rd_data  = rd_mux;
            assign rd_valid = rd_en;
        end
    endgenerate

endmodule

// File: tb/tb_coef_ram_ctrl.sv
// tb/tb_coef_ram_ctrl.sv - self-checking bench for coef_ram_ctrl
module tb_coef_ram_ctrl;

    localparam int D = 757;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_start;
    logic        busy;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [25:0] wr_data;
    logic        wr_err;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [25:0] rd_data;
    logic        rd_valid;
    logic        deg_we;
    logic [10:0] deg_in;
    logic [10:0] deg_out;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_on = 1'b0;

    logic [25:0] mm [0:2047];
    int          clear_left;
    logic [10:0] m_deg;
    logic        m_err;
    logic        m_valid;
    logic [25:0] m_rd;

    coef_ram_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .deg_we    (deg_we),
        .deg_in    (deg_in),
        .deg_out   (deg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mm[i] = '0;
    end

    // Model: clear walks addresses 0..D-1 one per cycle; reads see pre-edge contents.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left <= 0;
            m_deg      <= '0;
            m_err      <= 1'b0;
            m_valid    <= 1'b0;
            m_rd       <= '0;
        end else begin
            m_err   <= wr_en && (clear_left != 0 || int'(wr_addr) >= D);
            m_valid <= rd_en;
            if (rd_en) m_rd <= (int'(rd_addr) < D) ? mm[rd_addr] : 26'd0;
            if (clear_left != 0) begin
                mm[D - clear_left] <= '0;
                clear_left <= clear_left - 1;
            end else begin
                if (wr_en && int'(wr_addr) < D) mm[wr_addr] <= wr_data;
                if (clr_start) begin
                    clear_left <= D;
                    m_deg      <= '0;
                end else if (deg_we) begin
                    m_deg <= deg_in;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("m_busy",     32'(busy),     32'(clear_left != 0));
            chk("m_wr_err",   32'(wr_err),   32'(m_err));
            chk("m_deg_out",  32'(deg_out),  32'(m_deg));
            chk("m_rd_valid", 32'(rd_valid), 32'(m_valid));
            chk("m_rd_data",  32'(rd_data),  32'(m_rd));
        end
    end

    task automatic do_wr(input logic [10:0] a, input logic [25:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_rd(input string nm, input logic [10:0] a, input logic [25:0] exp);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        chk({nm, "_data"},  32'(rd_data),  32'(exp));
        chk({nm, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr_start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; deg_we = 1'b0; deg_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_wr_err",   32'(wr_err),   32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        chk("rst_deg",      32'(deg_out),  32'd0);

        // Full clear and its exact length
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        wait_idle(n);
        chk("clr_len", 32'(n), 32'd757);
        do_rd("clr_rd0",   11'd0,   26'd0);
        do_rd("clr_rd378", 11'd378, 26'd0);
        do_rd("clr_rd756", 11'd756, 26'd0);
        chk("clr_deg", 32'(deg_out), 32'd0);

        // Boundary writes, back-to-back reads
        do_wr(11'd5,   26'h3FFFFFF);
        do_wr(11'd756, 26'h0000123);
        rd_en = 1'b1; rd_addr = 11'd5;
        @(negedge clk);
        chk("b2b_5",   32'(rd_data),  32'h3FFFFFF);
        chk("b2b_v5",  32'(rd_valid), 32'd1);
        rd_addr = 11'd756;
        @(negedge clk);
        rd_en = 1'b0;
        chk("b2b_756", 32'(rd_data),  32'h0000123);
        chk("b2b_v756", 32'(rd_valid), 32'd1);
        @(negedge clk);
        chk("b2b_vend", 32'(rd_valid), 32'd0);
        chk("b2b_hold", 32'(rd_data),  32'h0000123);

        // Out-of-range write and read
        do_wr(11'd757, 26'h1555555);
        chk("oor_wr_err", 32'(wr_err), 32'd1);
        @(negedge clk);
        chk("oor_wr_err_end", 32'(wr_err), 32'd0);
        do_rd("oor_rd2047", 11'd2047, 26'd0);
        do_rd("oor_rd756", 11'd756, 26'h0000123);

        // Read-first on a same-cycle write
        do_wr(11'd10, 26'h55);
        wr_en = 1'b1; wr_addr = 11'd10; wr_data = 26'hAA;
        rd_en = 1'b1; rd_addr = 11'd10;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rf_old", 32'(rd_data), 32'h55);
        do_rd("rf_new", 11'd10, 26'hAA);

        // Degree load, then load colliding with a clear, then a write during busy
        deg_we = 1'b1; deg_in = 11'd756;
        @(negedge clk);
        deg_we = 1'b0;
        chk("deg_756", 32'(deg_out), 32'd756);
        deg_we = 1'b1; deg_in = 11'd300; clr_start = 1'b1;
        @(negedge clk);
        deg_we = 1'b0; clr_start = 1'b0;
        chk("deg_clr", 32'(deg_out), 32'd0);
        chk("deg_clr_busy", 32'(busy), 32'd1);
        deg_we = 1'b1; deg_in = 11'd123;
        do_wr(11'd20, 26'hBEEF);
        deg_we = 1'b0;
        chk("busy_wr_err", 32'(wr_err), 32'd1);
        chk("busy_deg_ign", 32'(deg_out), 32'd0);
        do_rd("busy_rd5", 11'd5, 26'h3FFFFFF);
        wait_idle(n);
        do_rd("busy_wr_drop", 11'd20, 26'd0);

        // Reset in the middle of a clear
        do_wr(11'd50,  26'h777);
        do_wr(11'd500, 26'h1234);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (99) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("mid_rst_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        do_rd("mid_rd50",  11'd50,  26'd0);
        do_rd("mid_rd500", 11'd500, 26'h1234);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        wait_idle(n);
        chk("reclr_len", 32'(n), 32'd757);
        do_rd("reclr_rd500", 11'd500, 26'd0);
        do_rd("reclr_rd756", 11'd756, 26'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coef_ram_ctrl.md
Name: coef_ram_ctrl

Overview:
Parametrised polynomial-coefficient store for the SNTRUP757 datapath. It is the generalised successor of the per-stage distributed coefficient RAMs.
- Wraps a distributed RAM with selectable read latency, range-checked access and zero-return for out-of-range reads.
- Holds a registered polynomial-degree field.
- Contains a hardware clear sequencer that zero-fills all DEPTH coefficients between polynomial operations.

Parameters:
DATA_W, 26, coefficient width in bits
ADDR_W, 11, address width
DEPTH, 757, number of valid coefficients; must satisfy 1 <= DEPTH <= 2**ADDR_W
RD_REG, 1, read mode: 0 = combinational read, 1 = registered read (1-cycle latency)
DEG_W, 11, degree field width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
clr_start  in  1  single-cycle request to zero-fill the RAM
busy  out  1  high while the clear sequencer runs
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_err  out  1  one-cycle pulse when a write is rejected
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data is valid
deg_we  in  1  degree load strobe
deg_in  in  DEG_W  degree value to load
deg_out  out  DEG_W  registered degree

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: busy=0, wr_err=0, rd_valid=0, rd_data=0 (RD_REG=1), deg_out=0; sequencer in IDLE with clr_cnt=0.
- RAM contents are not reset; only clr_start zeroes them.
- Sequencer has two states, IDLE and CLEAR.
- IDLE -> CLEAR when clr_start=1. On that edge clr_cnt<=0 and deg_out<=0.
- In CLEAR, every cycle writes mem[clr_cnt]<=0 and then clr_cnt++.
- After the write at DEPTH-1, CLEAR -> IDLE. busy is high for exactly DEPTH cycles, starting the cycle after clr_start.
- clr_start while busy=1 is ignored.
- User writes are accepted when wr_en=1, busy=0 and wr_addr<DEPTH; mem is written on the rising edge.
- Rejected writes: wr_addr>=DEPTH, or wr_en=1 while busy=1. The write is dropped and wr_err=1 on the next cycle, for one cycle.
- Reads with rd_addr>=DEPTH return 0 in both modes.
- RD_REG=0:
  - rd_data = (rd_addr<DEPTH) ? mem[rd_addr] : 0, combinationally.
  - rd_valid = rd_en, combinationally.
  - A same-address write becomes visible after the edge.
- RD_REG=1:
  - On an edge with rd_en=1, rd_data<=range-checked mem[rd_addr] and rd_valid<=1.
  - When rd_en=0, rd_valid<=0 and rd_data holds its value.
  - Read-first: a same-cycle write to the same address returns the OLD data.
- Reads are allowed during CLEAR and return current contents, which may be partially cleared.
- Degree: deg_we=1 in IDLE loads deg_out<=deg_in on the next edge.
- deg_we during busy is ignored.
- deg_we together with clr_start: clear wins and deg_out=0.
- rst asserted mid-CLEAR: returns to IDLE immediately, busy=0. The memory is left partially cleared; this is legal and software must re-issue clr_start.
- No combinational path from any input to busy, wr_err or deg_out.

Decomposition:
- Shared package sntrup_pkg holds:
  - constants P=757, COEF_W=26, ADDR_W=11, DEG_W=11;
  - typedef coef_t = logic [COEF_W-1:0];
  - typedef clr_state_t = enum {IDLE, CLEAR}.
- One sub-module, dist_ram_sp: a single synchronous write port and an asynchronous read port, with ram_style "distributed".
- Write-port muxing (sequencer vs user), range checks and read registering stay in coef_ram_ctrl.

Test Plan:
- Reset, then clr_start pulse -> busy=1 for exactly 757 cycles and then 0. Reads of addresses 0, 378 and 756 return 0. deg_out=0.
- RD_REG=1: write 0x3FFFFFF@5 and 0x0000123@756. Read 5 then 756 back-to-back -> rd_data 0x3FFFFFF then 0x0000123, each 1 cycle after rd_en, with rd_valid aligned.
- Write to addr 757 -> no RAM change, wr_err pulses 1 cycle. Read addr 2047 -> rd_data=0, rd_valid=1.
- RD_REG=1: same-cycle write 0xAA and read at addr 10, old value 0x55 -> rd_data=0x55. Next read of addr 10 -> 0xAA.
- deg_we with deg_in=756 -> deg_out=756. Then deg_we=1 with deg_in=300 together with clr_start -> deg_out=0, busy=1. wr_en during busy -> wr_err=1 and data not stored.
- Assert rst at clear cycle 100 -> busy=0 immediately. Addr 50 reads 0; addr 500 retains its prior value. A new clr_start runs the full 757 cycles.
